dpe_routing_table: RTL and testbench

//  Hardware egress routing table behind the CSR external routing_table window, written by the management CPU.

---
 rtl/dpe_routing_table.sv | 133 +++++++++++++
 tb/tb_dpe_routing_table.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpe_routing_table.sv
// dpe_routing_table: CSR-programmed egress routing table with 2-stage first-match IPv4 lookup; optional counters under ROUTE_STATS_EN
package dpe_routing_table_pkg;
  typedef struct packed {
    logic        req;
    logic        req_is_wr;
    logic [3:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] wr_biten;
  } csr__dpe__routing_table__external__out_t;
  typedef struct packed {
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        wr_ack;
  } csr__dpe__routing_table__external__in_t;
  typedef enum logic {IDLE, ACK} csr_state_t;
endpackage

module dpe_routing_table
  import dpe_routing_table_pkg::*;
#(
  parameter int ENTRY_COUNT = 64,
  localparam int IW = $clog2(ENTRY_COUNT)
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  csr__dpe__routing_table__external__out_t [ENTRY_COUNT-1:0] csr_req,
  output csr__dpe__routing_table__external__in_t  [ENTRY_COUNT-1:0] csr_rsp,
  input  logic                                                     lkp_valid,
  output logic                                                     lkp_ready,
  input  logic [31:0]                                              lkp_ip,
  output logic                                                     res_valid,
  input  logic                                                     res_ready,
  output logic                                                     res_hit,
  output logic [IW-1:0]                                            res_idx,
  output logic [2:0]                                               res_dst_port,
  output logic [7:0]                                               res_peer_id
`ifdef ROUTE_STATS_EN
  ,
  output logic [31:0]                                              stat_lookups,
  output logic [31:0]                                              stat_misses
`endif
);
  logic [ENTRY_COUNT-1:0] match;
  logic [ENTRY_COUNT-1:0][2:0] dst_all;
  logic [ENTRY_COUNT-1:0][7:0] peer_all;
  for (genvar i = 0; i < ENTRY_COUNT; i++) begin : g_ent
    csr_state_t st;
    csr__dpe__routing_table__external__out_t q;
    logic [31:0] prefix, mask, fld, nxt, rd_data;
    logic [7:0] peer;
    logic [2:0] dst;
    logic vld, rd_ack, wr_ack;
    assign q = csr_req[i];
    assign fld = q.addr == 4'd0 ? prefix : q.addr == 4'd4 ? mask :
                 q.addr == 4'd8 ? {24'd0, peer} : q.addr == 4'd12 ? {29'd0, dst} : '0;
    assign nxt = (fld & ~q.wr_biten) | (q.wr_data & q.wr_biten);
    // per-entry CSR handshake: accept in IDLE, one-cycle ack, PREFIX write arms the entry
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st <= IDLE;
        prefix <= '0;
        mask <= '0;
        peer <= '0;
        dst <= '0;
        vld <= 1'b0;
        rd_ack <= 1'b0;
        wr_ack <= 1'b0;
        rd_data <= '0;
      end else if (st == ACK) begin
        st <= IDLE;
        rd_ack <= 1'b0;
        wr_ack <= 1'b0;
      end else if (q.req) begin
        st <= ACK;
        rd_ack <= !q.req_is_wr;
        wr_ack <= q.req_is_wr;
        rd_data <= q.req_is_wr ? '0 : fld;
        if (q.req_is_wr && q.addr == 4'd0) begin prefix <= nxt; vld <= 1'b1; end
        if (q.req_is_wr && q.addr == 4'd4) begin mask <= nxt; vld <= 1'b0; end
        if (q.req_is_wr && q.addr == 4'd8) begin peer <= nxt[7:0]; vld <= 1'b0; end
        if (q.req_is_wr && q.addr == 4'd12) begin dst <= nxt[2:0]; vld <= 1'b0; end
      end
    assign match[i] = vld && ((lkp_ip & mask) == (prefix & mask));
    assign dst_all[i] = dst;
    assign peer_all[i] = peer;
    assign csr_rsp[i] = '{rd_ack: rd_ack, rd_data: rd_data, wr_ack: wr_ack};
  end
  logic adv, s1_valid, hit;
  logic [ENTRY_COUNT-1:0] s1_match;
  logic [IW-1:0] idx;
  assign adv = !res_valid || res_ready;
  assign lkp_ready = adv;
  // lowest matching index wins (table is pre-sorted longest prefix first)
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = ENTRY_COUNT - 1; k >= 0; k--)
      if (s1_match[k]) begin
        hit = 1'b1;
        idx = IW'(k);
      end
  end
  // two-stage lookup pipeline; both stages freeze while the result is held
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
      res_valid <= 1'b0;
      res_hit <= 1'b0;
      res_idx <= '0;
      res_dst_port <= '0;
      res_peer_id <= '0;
    end else if (adv) begin
      s1_valid <= lkp_valid;
      s1_match <= lkp_valid ? match : '0;
      res_valid <= s1_valid;
      res_hit <= hit;
      res_idx <= idx;
      res_dst_port <= hit ? dst_all[idx] : '0;
      res_peer_id <= hit ? peer_all[idx] : '0;
    end
`ifdef ROUTE_STATS_EN
  // saturating counters of delivered results and misses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_lookups <= '0;
      stat_misses <= '0;
    end else if (res_valid && res_ready) begin
      if (stat_lookups != '1) stat_lookups <= stat_lookups + 32'd1;
      if (!res_hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dpe_routing_table.sv
// tb_dpe_routing_table: directed checks of CSR access and routing lookups for dpe_routing_table
module tb_dpe_routing_table;
  import dpe_routing_table_pkg::*;
  localparam int N = 64;
  logic clk, rst;
  csr__dpe__routing_table__external__out_t [N-1:0] csr_req;
  csr__dpe__routing_table__external__in_t  [N-1:0] csr_rsp;
  logic lkp_valid, lkp_ready, res_valid, res_ready, res_hit;
  logic [31:0] lkp_ip;
  logic [5:0] res_idx;
  logic [2:0] res_dst_port;
  logic [7:0] res_peer_id;
`ifdef ROUTE_STATS_EN
  logic [31:0] stat_lookups, stat_misses;
`endif
  int checks, errors, n, m;
  logic [31:0] ips [4];
  logic [5:0] eidx [4];

  dpe_routing_table #(.ENTRY_COUNT(N)) dut (
    .clk(clk), .rst(rst), .csr_req(csr_req), .csr_rsp(csr_rsp),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_ip(lkp_ip),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_idx(res_idx), .res_dst_port(res_dst_port), .res_peer_id(res_peer_id)
`ifdef ROUTE_STATS_EN
    , .stat_lookups(stat_lookups), .stat_misses(stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input int e, input logic [3:0] a, input logic [31:0] d, input logic [31:0] be);
    csr_req[e] = '{req: 1'b1, req_is_wr: 1'b1, addr: a, wr_data: d, wr_biten: be};
    @(posedge clk); #1;
    csr_req[e] = '0;
    chk($sformatf("wr_ack e%0d a%0d", e, a), 32'(csr_rsp[e].wr_ack), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic csr_rd(input int e, input logic [3:0] a, input logic [31:0] exp);
    csr_req[e] = '{req: 1'b1, req_is_wr: 1'b0, addr: a, wr_data: 32'd0, wr_biten: 32'd0};
    @(posedge clk); #1;
    csr_req[e] = '0;
    chk($sformatf("rd_ack e%0d a%0d", e, a), 32'(csr_rsp[e].rd_ack), 32'd1);
    chk($sformatf("rd_data e%0d a%0d", e, a), csr_rsp[e].rd_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic wr_entry(input int e, input logic [31:0] pfx, input logic [31:0] msk,
                          input logic [7:0] peer, input logic [2:0] dst);
    csr_wr(e, 4'd4, msk, 32'hFFFF_FFFF);
    csr_wr(e, 4'd8, 32'(peer), 32'hFFFF_FFFF);
    csr_wr(e, 4'd12, 32'(dst), 32'hFFFF_FFFF);
    csr_wr(e, 4'd0, pfx, 32'hFFFF_FFFF);
  endtask

  task automatic lookup(input string tag, input logic [31:0] ip, input logic h,
                        input logic [5:0] i, input logic [2:0] d, input logic [7:0] p);
    lkp_ip = ip;
    lkp_valid = 1'b1;
    chk({tag, " ready"}, 32'(lkp_ready), 32'd1);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk({tag, " valid early"}, 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(res_valid), 32'd1);
    chk({tag, " hit"}, 32'(res_hit), 32'(h));
    chk({tag, " idx"}, 32'(res_idx), 32'(i));
    chk({tag, " dst"}, 32'(res_dst_port), 32'(d));
    chk({tag, " peer"}, 32'(res_peer_id), 32'(p));
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    csr_req = '0;
    lkp_valid = 1'b0;
    lkp_ip = '0;
    res_ready = 1'b1;
    ips = '{32'h0A0A_0A0A, 32'h0A0A_0901, 32'h0A09_0001, 32'h0808_0808};
    eidx = '{6'd0, 6'd1, 6'd2, 6'd3};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst lkp_ready", 32'(lkp_ready), 32'd1);
    chk("rst res_hit", 32'(res_hit), 32'd0);
    chk("rst res_idx", 32'(res_idx), 32'd0);
    checks++;
    assert (csr_rsp === '0) else begin
      errors++;
      $error("FAIL rst csr_rsp observed nonzero expected 0");
    end
`ifdef ROUTE_STATS_EN
    chk("rst stat_lookups", stat_lookups, 32'd0);
    chk("rst stat_misses", stat_misses, 32'd0);
`endif
    lookup("empty miss", 32'h0A01_0203, 1'b0, 6'd0, 3'd0, 8'd0);
    wr_entry(0, 32'h0A0A_0A0A, 32'hFFFF_FFFF, 8'd102, 3'd3);
    wr_entry(1, 32'h0A0A_0000, 32'hFFFF_0000, 8'd101, 3'd2);
    wr_entry(2, 32'h0A00_0000, 32'hFF00_0000, 8'd100, 3'd1);
    wr_entry(3, 32'h0000_0000, 32'h0000_0000, 8'd255, 3'd1);
    lookup("lpm /32", 32'h0A0A_0A0A, 1'b1, 6'd0, 3'd3, 8'd102);
    lookup("lpm /16", 32'h0A0A_0901, 1'b1, 6'd1, 3'd2, 8'd101);
    lookup("lpm /8", 32'h0A09_0001, 1'b1, 6'd2, 3'd1, 8'd100);
    lookup("lpm default", 32'h0808_0808, 1'b1, 6'd3, 3'd1, 8'd255);
    csr_req[5] = '{req: 1'b1, req_is_wr: 1'b1, addr: 4'd8, wr_data: 32'hFFFF_FF2A, wr_biten: 32'h0000_00FF};
    @(posedge clk); #1;
    chk("held req ack c1", 32'(csr_rsp[5].wr_ack), 32'd1);
    @(posedge clk); #1;
    chk("held req ack c2", 32'(csr_rsp[5].wr_ack), 32'd0);
    @(posedge clk); #1;
    csr_req[5] = '0;
    chk("held req ack c3", 32'(csr_rsp[5].wr_ack), 32'd1);
    @(posedge clk); #1;
    chk("held req ack c4", 32'(csr_rsp[5].wr_ack), 32'd0);
    csr_rd(5, 4'd8, 32'h0000_002A);
    csr_rd(0, 4'd12, 32'd3);
    csr_rd(0, 4'd8, 32'd102);
    csr_rd(1, 4'd4, 32'hFFFF_0000);
    csr_rd(0, 4'd2, 32'd0);
    csr_wr(0, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lookup("unmapped wr no effect", 32'h0A0A_0A0A, 1'b1, 6'd0, 3'd3, 8'd102);
    csr_req[0] = '{req: 1'b1, req_is_wr: 1'b1, addr: 4'd4, wr_data: 32'hFFFF_FFFF, wr_biten: 32'hFFFF_FFFF};
    lkp_ip = 32'h0A0A_0A0A;
    lkp_valid = 1'b1;
    @(posedge clk); #1;
    csr_req[0] = '0;
    lkp_valid = 1'b0;
    chk("same-cycle wr ack", 32'(csr_rsp[0].wr_ack), 32'd1);
    @(posedge clk); #1;
    chk("same-cycle valid", 32'(res_valid), 32'd1);
    chk("same-cycle sees old idx", 32'(res_idx), 32'd0);
    chk("same-cycle sees old hit", 32'(res_hit), 32'd1);
    @(posedge clk); #1;
    lookup("vld cleared", 32'h0A0A_0A0A, 1'b1, 6'd1, 3'd2, 8'd101);
    csr_wr(0, 4'd0, 32'h0A0A_0A0A, 32'hFFFF_FFFF);
    lookup("prefix rearms", 32'h0A0A_0A0A, 1'b1, 6'd0, 3'd3, 8'd102);
    n = 0;
    m = 0;
    for (int c = 0; c < 20 && m < 4; c++) begin
      res_ready = !(c >= 1 && c <= 3);
      lkp_valid = n < 4;
      lkp_ip = ips[n < 4 ? n : 0];
      @(negedge clk);
      if (c == 2 || c == 3) begin
        chk($sformatf("stall lkp_ready c%0d", c), 32'(lkp_ready), 32'd0);
        chk($sformatf("stall res_valid c%0d", c), 32'(res_valid), 32'd1);
      end
      if (lkp_valid && lkp_ready) n++;
      if (res_valid && res_ready) begin
        chk($sformatf("bp idx #%0d", m), 32'(res_idx), 32'(eidx[m]));
        chk($sformatf("bp hit #%0d", m), 32'(res_hit), 32'd1);
        m++;
      end
      @(posedge clk); #1;
    end
    lkp_valid = 1'b0;
    res_ready = 1'b1;
    chk("bp result count", 32'(m), 32'd4);
    chk("bp no extra result", 32'(res_valid), 32'd0);
`ifdef ROUTE_STATS_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("stats cleared", stat_lookups, 32'd0);
    wr_entry(0, 32'h0A0A_0A0A, 32'hFFFF_FFFF, 8'd102, 3'd3);
    lookup("st1", 32'h0A0A_0A0A, 1'b1, 6'd0, 3'd3, 8'd102);
    lookup("st2", 32'h0102_0304, 1'b0, 6'd0, 3'd0, 8'd0);
    lookup("st3", 32'h0A0A_0A0A, 1'b1, 6'd0, 3'd3, 8'd102);
    lookup("st4", 32'h0505_0505, 1'b0, 6'd0, 3'd0, 8'd0);
    lookup("st5", 32'h0A0A_0A0A, 1'b1, 6'd0, 3'd3, 8'd102);
    chk("stat_lookups", stat_lookups, 32'd5);
    chk("stat_misses", stat_misses, 32'd2);
`endif
    lkp_ip = 32'h0A0A_0A0A;
    lkp_valid = 1'b1;
    @(posedge clk); #1;
    csr_req[1] = '{req: 1'b1, req_is_wr: 1'b1, addr: 4'd0, wr_data: 32'h0A0A_0000, wr_biten: 32'hFFFF_FFFF};
    @(posedge clk); #1;
    csr_req[1] = '0;
    chk("pre-rst res_valid", 32'(res_valid), 32'd1);
    chk("pre-rst wr_ack", 32'(csr_rsp[1].wr_ack), 32'd1);
    res_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst res_valid", 32'(res_valid), 32'd0);
    chk("async rst res_hit", 32'(res_hit), 32'd0);
    chk("async rst res_idx", 32'(res_idx), 32'd0);
    chk("async rst res_dst", 32'(res_dst_port), 32'd0);
    chk("async rst res_peer", 32'(res_peer_id), 32'd0);
    chk("async rst lkp_ready", 32'(lkp_ready), 32'd1);
    checks++;
    assert (csr_rsp === '0) else begin
      errors++;
      $error("FAIL async rst csr_rsp observed nonzero expected 0");
    end
`ifdef ROUTE_STATS_EN
    chk("async rst stat_lookups", stat_lookups, 32'd0);
    chk("async rst stat_misses", stat_misses, 32'd0);
`endif
    lkp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("dropped in-flight c1", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk("dropped in-flight c2", 32'(res_valid), 32'd0);
    lookup("table cleared", 32'h0A0A_0A0A, 1'b0, 6'd0, 3'd0, 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
